// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial FIR filter: FSM states, accumulator
// sizing, default coefficient set and the round/saturate stage.
package fir_pkg;

    localparam int unsigned MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Wide enough that TAPS full-scale products can never overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + int'($clog2(taps));
    endfunction

    // Low-pass set for 8 taps, unity otherwise; clamped to what coef_w can hold.
    function automatic int default_coef(input int unsigned taps,
                                        input int unsigned coef_w,
                                        input int unsigned k);
        int c;
        int cmax;
        c = 1;
        if (taps == 8) begin
            case (k)
                0, 7:    c = 36;
                1, 6:    c = 196;
                2, 5:    c = 672;
                3, 4:    c = 1144;
                default: c = 1;
            endcase
        end
        cmax = (coef_w >= 32) ? 32'h7fff_ffff : ((1 << (coef_w - 1)) - 1);
        return (c > cmax) ? cmax : c;
    endfunction

    // Round half up by the shift amount, arithmetic shift, then clamp to out_w bits.
    function automatic logic signed [MAX_W-1:0] sat_round(input logic signed [MAX_W-1:0] v,
                                                          input int unsigned shift,
                                                          input int unsigned out_w);
        logic signed [MAX_W-1:0] r;
        logic signed [MAX_W-1:0] one;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        one = MAX_W'(1);
        r   = v;
        if (shift > 0) begin
            r = signed'(r + (one <<< (shift - 1))) >>> shift;
        end
        hi = (one <<< (out_w - 1)) - one;
        lo = -hi - one;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_filter_serial_if.sv
// Sample-in / result-out valid-ready bundle for the serial FIR filter.
interface fir_filter_serial_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep circular sample buffer: one write port, one asynchronous read index,
// synchronous clear.
module fir_delay_line #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 8
) (
    input  logic                       clk,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(TAPS)-1:0]    wr_idx_i,
    input  logic signed [DATA_W-1:0]   wr_data_i,
    input  logic [$clog2(TAPS)-1:0]    rd_idx_i,
    output logic signed [DATA_W-1:0]   rd_data_c_o
);

    logic signed [DATA_W-1:0] mem_q [TAPS];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fir_filter_serial.sv
// Time-multiplexed FIR: one MAC per clock over a circular sample buffer, rounded
// and saturated output. Define FIR_COEF_LOAD_EN for runtime-writable coefficients.
module fir_filter_serial
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned OUT_SHIFT = 0
) (
    input logic                 clk,
    input logic                 reset,
    fir_filter_serial_if.slave  bus
`ifdef FIR_COEF_LOAD_EN
    ,
    input logic                      coef_wr_en,
    input logic [$clog2(TAPS)-1:0]   coef_wr_addr,
    input logic signed [COEF_W-1:0]  coef_wr_data
`endif
);

    localparam int unsigned IDX_W  = $clog2(TAPS);
    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    fir_state_e               state_q;
    logic [IDX_W-1:0]         wr_ptr_q;
    logic [IDX_W-1:0]         wr_ptr_d;
    logic [IDX_W-1:0]         base_q;
    logic [IDX_W-1:0]         k_q;
    logic [IDX_W-1:0]         rd_idx_c;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [DATA_W-1:0] sample_c;
    logic signed [COEF_W-1:0] coef_c [TAPS];
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [OUT_W-1:0]  out_data_d;
    logic                     accept_c;
    logic                     last_tap_c;

    assign bus.in_ready  = (state_q == IDLE) && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign accept_c      = bus.in_valid && bus.in_ready;

`ifdef FIR_COEF_LOAD_EN
    logic signed [COEF_W-1:0] coef_q [TAPS];

    // Writes only land while idle so an in-flight sum never sees mixed coefficients.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                coef_q[i] <= COEF_W'(default_coef(TAPS, COEF_W, i));
            end
        end else if (coef_wr_en && (state_q == IDLE) && (32'(coef_wr_addr) < TAPS)) begin
            coef_q[coef_wr_addr] <= coef_wr_data;
        end
    end

    assign coef_c = coef_q;
`else
    for (genvar g = 0; g < int'(TAPS); g++) begin : g_coef
        assign coef_c[g] = COEF_W'(default_coef(TAPS, COEF_W, g));
    end
`endif

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_delay_line (
        .clk         (clk),
        .clr_i       (reset),
        .wr_en_i     (accept_c),
        .wr_idx_i    (wr_ptr_q),
        .wr_data_i   (bus.in_data),
        .rd_idx_i    (rd_idx_c),
        .rd_data_c_o (sample_c)
    );

    // Tap k reads the sample k positions behind the one just accepted.
    always_comb begin
        wr_ptr_d   = (wr_ptr_q == IDX_W'(TAPS - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
        rd_idx_c   = (base_q >= k_q) ? (base_q - k_q) : (base_q + IDX_W'(TAPS) - k_q);
        last_tap_c = (k_q == IDX_W'(TAPS - 1));
        prod_c     = coef_c[k_q] * sample_c;
        acc_d      = acc_q + ACC_W'(prod_c);
        out_data_d = OUT_W'(sat_round(MAX_W'(acc_d), OUT_SHIFT, OUT_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        wr_ptr_q <= wr_ptr_d;
                        base_q   <= wr_ptr_q;
                        k_q      <= '0;
                        acc_q    <= '0;
                        state_q  <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + IDX_W'(1);
                    if (last_tap_c) begin
                        out_data_q  <= out_data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_serial.sv
// Scoreboard bench for fir_filter_serial: a direct-convolution model predicts each
// result at sample accept; a saturating 16-bit-output instance runs alongside.
module tb_fir_filter_serial;

    localparam int unsigned TAPS = 8;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    fir_filter_serial_if #(.DATA_W(16), .OUT_W(32)) bus_a ();
    fir_filter_serial_if #(.DATA_W(16), .OUT_W(16)) bus_b ();

`ifdef FIR_COEF_LOAD_EN
    logic               coef_wr_en;
    logic [2:0]         coef_wr_addr;
    logic signed [15:0] coef_wr_data;
`endif

    fir_filter_serial #(
        .DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32), .OUT_SHIFT(0)
    ) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a.slave)
`ifdef FIR_COEF_LOAD_EN
        ,
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data)
`endif
    );

    fir_filter_serial #(
        .DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(16), .OUT_SHIFT(0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
`ifdef FIR_COEF_LOAD_EN
        ,
        .coef_wr_en   (1'b0),
        .coef_wr_addr (3'd0),
        .coef_wr_data (16'sd0)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: newest sample first, coefficients as the DUT should hold them.
    longint lp_coef [TAPS] = '{36, 196, 672, 1144, 1144, 672, 196, 36};
    longint h_m [TAPS];
    int     hist [$];
    longint exp_a [$];
    int     out_idx = 0;

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < int'(TAPS); k++) begin
            if (k < hist.size()) s += h_m[k] * longint'(hist[k]);
        end
        if (s > 64'sd2147483647)  s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s;
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_a.delete();
        for (int k = 0; k < int'(TAPS); k++) h_m[k] = lp_coef[k];
    endfunction

    task automatic send_a(input int x);
        int w = 0;
        @(negedge clk);
        while (!bus_a.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", bus_a.in_ready, 1);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 16'(x);
        hist.push_front(x);
        if (hist.size() > int'(TAPS)) void'(hist.pop_back());
        exp_a.push_back(model_y());
        @(posedge clk);
        #1 bus_a.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (exp_a.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check(tag, exp_a.size(), 0);
    endtask

    task automatic reset_a();
        @(posedge clk);
        #1 rst = 1'b1;
        bus_a.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus_a.in_ready, 0);
        check("rst_out_valid", bus_a.out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

`ifdef FIR_COEF_LOAD_EN
    task automatic write_coef(input int a, input int v);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 3'(a);
        coef_wr_data = 16'(v);
        @(posedge clk);
        #1 coef_wr_en = 1'b0;
    endtask
`endif

    always @(negedge clk) begin
        if (!rst && bus_a.out_valid && bus_a.out_ready) begin
            if (exp_a.size() == 0) begin
                check("unexpected_out", bus_a.out_valid, 0);
            end else begin
                check($sformatf("out_a[%0d]", out_idx), bus_a.out_data, exp_a.pop_front());
                out_idx++;
            end
        end
    end

    // Saturating instance: driven flat out, every result must sit on the rail.
    int b_cnt   = 0;
    bit b_neg   = 1'b0;
    bit b_done  = 1'b0;

    always @(negedge clk) begin
        if (!rst_b && bus_b.out_valid && bus_b.out_ready) begin
            check(b_neg ? "sat_neg" : "sat_pos", bus_b.out_data, b_neg ? -64'sd32768 : 64'sd32767);
            b_cnt++;
        end
    end

    initial begin
        int w;
        rst_b = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b1;
        bus_b.in_data   = 16'sh7fff;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        bus_b.in_valid = 1'b1;
        w = 0;
        while (b_cnt < 10 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("sat_pos_count", b_cnt >= 10, 1);
        #1 rst_b = 1'b1;
        b_neg = 1'b1;
        bus_b.in_data = 16'sh8000;
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        b_cnt = 0;
        w = 0;
        while (b_cnt < 10 && w < 500) begin
            @(posedge clk);
            w++;
        end
        check("sat_neg_count", b_cnt >= 10, 1);
        b_done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.out_ready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus_a.in_ready, 0);
        check("reset_out_valid", bus_a.out_valid, 0);
        check("reset_out_data", bus_a.out_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus_a.in_ready, 1);

        // Impulse, then step.
        send_a(1);
        for (int i = 0; i < 8; i++) send_a(0);
        drain("drain_impulse");
        for (int i = 0; i < 10; i++) send_a(100);
        drain("drain_step");

        // Backpressure with a stray in_valid pulse that must be ignored.
        @(posedge clk);
        #1 bus_a.out_ready = 1'b0;
        send_a(-250);
        w = 0;
        while (!bus_a.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_rise", bus_a.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", bus_a.out_valid, 1);
            check("bp_out_data", bus_a.out_data, (exp_a.size() > 0) ? exp_a[0] : 64'sd0);
            check("bp_in_ready", bus_a.in_ready, 0);
            bus_a.in_valid = (i == 2);
            bus_a.in_data  = 16'sd777;
            @(negedge clk);
        end
        bus_a.in_valid = 1'b0;
        @(posedge clk);
        #1 bus_a.out_ready = 1'b1;
        send_a(3);
        send_a(-4);
        drain("drain_bp");

`ifdef FIR_COEF_LOAD_EN
        for (int a = 0; a < int'(TAPS); a++) begin
            write_coef(a, (a == 0) ? 1 : 0);
            h_m[a] = (a == 0) ? 1 : 0;
        end
        send_a(5);
        send_a(-7);
        send_a(9);
        drain("drain_coef");
        send_a(11);
        write_coef(1, 1000);
        send_a(13);
        drain("drain_coef_mac");
`endif

        // Abort a computation at tap 3; nothing may come out of it.
        reset_a();
        send_a(1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i % 5 == 0) check("abort_no_valid", bus_a.out_valid, 0);
        end
        send_a(1);
        for (int i = 0; i < 8; i++) send_a(0);
        drain("drain_after_abort");

        w = 0;
        while (!b_done && w < 2000) begin
            @(posedge clk);
            w++;
        end
        check("sat_done", b_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
